// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the RV32I pipeline hazard controller.
// Holds the FSM state encoding, the forwarding selects and the register-match helper.
package hazard_ctrl_pkg;

   localparam int REG_W   = 5;
   localparam int NUM_OPS = 2;

   typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} ctrl_state_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   // A later-stage writer as seen by the forwarding logic
   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic             we;
   } wr_src_t;

   // x0 is never a real producer, so it never matches
   function automatic logic reg_hit(input wr_src_t src, input logic [REG_W-1:0] rs);
      return src.we && (src.rd != '0) && (src.rd == rs);
   endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// EX operand forwarding select for one source operand.
// The MEM-stage result is younger than the WB-stage result, so it wins on a double match.
module fwd_sel
   import hazard_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] rs_e,
   input  wr_src_t          mem_src,
   input  wr_src_t          wb_src,
   output fwd_sel_t         sel
);

   always_comb begin
      sel = FWD_RF;
      if (reg_hit(mem_src, rs_e))
         sel = FWD_MEM;
      else if (reg_hit(wb_src, rs_e))
         sel = FWD_WB;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: stall/flush generation,
// EX forwarding, data-memory wait freeze with timeout flag, and stall/flush counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 256,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] Rs1_D,
   input  logic [REG_W-1:0] Rs2_D,
   input  logic [REG_W-1:0] Rs1_E,
   input  logic [REG_W-1:0] Rs2_E,
   input  logic [REG_W-1:0] Rd_E,
   input  logic [REG_W-1:0] Rd_M,
   input  logic [REG_W-1:0] Rd_W,
   input  logic             RegWrite_M,
   input  logic             RegWrite_W,
   input  logic             MemRead_E,
   input  logic             PCSrc_E,
   input  logic             MemReq_M,
   input  logic             MemReady_M,
   output logic             Stall_F,
   output logic             Stall_D,
   output logic             Stall_E,
   output logic             Stall_M,
   output logic             Flush_D,
   output logic             Flush_E,
   output logic             Flush_W,
   output logic [1:0]       ForwardA_E,
   output logic [1:0]       ForwardB_E,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   ctrl_state_t                   state, state_nxt;
   logic [WAIT_W-1:0]             wait_cnt;
   logic                          freeze, load_use;
   logic [NUM_OPS-1:0][REG_W-1:0] rs_e;
   fwd_sel_t                      fwd [NUM_OPS];
   wr_src_t                       mem_src, wb_src;

   assign rs_e    = {Rs2_E, Rs1_E};
   assign mem_src = '{rd: Rd_M, we: RegWrite_M};
   assign wb_src  = '{rd: Rd_W, we: RegWrite_W};

   for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
      fwd_sel u_fwd_sel (
         .rs_e    (rs_e[g]),
         .mem_src (mem_src),
         .wb_src  (wb_src),
         .sel     (fwd[g])
      );
   end

   // A request that completes in its first cycle never freezes the pipe
   assign freeze   = (MemReq_M || state == MEM_WAIT) && !MemReady_M;
   assign load_use = MemRead_E && (Rd_E != '0) && (Rd_E == Rs1_D || Rd_E == Rs2_D);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      Stall_F    = 1'b0;
      Stall_D    = 1'b0;
      Stall_E    = 1'b0;
      Stall_M    = 1'b0;
      Flush_D    = 1'b0;
      Flush_E    = 1'b0;
      Flush_W    = 1'b0;
      ForwardA_E = FWD_RF;
      ForwardB_E = FWD_RF;
      if (!rst) begin
         case (state)
            RUN:      if (MemReq_M && !MemReady_M) state_nxt = MEM_WAIT;
            MEM_WAIT: if (MemReady_M) state_nxt = RUN;
            default:  state_nxt = RUN;
         endcase
         ForwardA_E = fwd[0];
         ForwardB_E = fwd[1];
         // Branch and load-use stay pending under a freeze and act on the ready cycle
         if (freeze) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Stall_M = 1'b1;
            Flush_W = 1'b1;
         end else if (PCSrc_E) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
         end else if (load_use) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Flush_E = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else begin
         // Held at zero in RUN so every wait starts counting from zero
         if (state == RUN) begin
            wait_cnt <= '0;
         end else if (!MemReady_M && wait_cnt != WAIT_W'(MEM_TIMEOUT)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
            if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) mem_timeout <= 1'b1;
         end
         if (Stall_F) stall_cnt <= stall_cnt + CNT_W'(1);
         if (Flush_E) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected controls are queued as stimulus is driven
// and popped against the DUT outputs mid-cycle; counters are checked against a running model.
module tb_hazard_ctrl;

   localparam int CNT_W = 8;
   localparam int TMO   = 4;

   typedef struct packed {
      logic       memread;
      logic [4:0] rd_e, rs1_d, rs2_d;
      logic       pcsrc, memreq, memready;
      logic [4:0] rs1_e, rs2_e, rd_m, rd_w;
      logic       rwm, rww;
   } stim_t;

   typedef struct packed {
      logic       sf, sd, se, sm, fd, fe, fw;
      logic [1:0] fa, fb;
      logic       to;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
   logic RegWrite_M, RegWrite_W, MemRead_E, PCSrc_E, MemReq_M, MemReady_M;
   logic Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W, mem_timeout;
   logic [1:0] ForwardA_E, ForwardB_E;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   exp_t       sb[$];
   exp_t       obs;
   logic [CNT_W-1:0] exp_stall = '0;
   logic [CNT_W-1:0] exp_flush = '0;
   int vec = 0;
   int err = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
      .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
      .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W), .MemRead_E(MemRead_E),
      .PCSrc_E(PCSrc_E), .MemReq_M(MemReq_M), .MemReady_M(MemReady_M),
      .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
      .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_W(Flush_W),
      .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .mem_timeout(mem_timeout),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   assign obs = {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
                 ForwardA_E, ForwardB_E, mem_timeout};

   function automatic stim_t st(input logic mr, input logic [4:0] rde, rs1d, rs2d,
                                input logic pc, mq, mrdy,
                                input logic [4:0] rs1e, rs2e, rdm, rdw, input logic rwm, rww);
      return {mr, rde, rs1d, rs2d, pc, mq, mrdy, rs1e, rs2e, rdm, rdw, rwm, rww};
   endfunction

   // flags order: Stall_F Stall_D Stall_E Stall_M Flush_D Flush_E Flush_W
   function automatic exp_t mk(input logic [6:0] fl, input logic [1:0] fa, fb, input logic to);
      return {fl, fa, fb, to};
   endfunction

   task automatic drive(input stim_t s);
      MemRead_E = s.memread; Rd_E = s.rd_e; Rs1_D = s.rs1_d; Rs2_D = s.rs2_d;
      PCSrc_E = s.pcsrc; MemReq_M = s.memreq; MemReady_M = s.memready;
      Rs1_E = s.rs1_e; Rs2_E = s.rs2_e; Rd_M = s.rd_m; Rd_W = s.rd_w;
      RegWrite_M = s.rwm; RegWrite_W = s.rww;
   endtask

   task automatic push(input exp_t x);
      sb.push_back(x);
      if (x.sf) exp_stall = exp_stall + 1'b1;
      if (x.fe) exp_flush = exp_flush + 1'b1;
   endtask

   task automatic test_reset();
      exp_t e;
      drive(st(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 5'd7, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1));
      push(mk(7'b0, 2'b00, 2'b00, 1'b0));
      @(negedge clk);
      e = sb.pop_front(); vec++;
      if (obs !== e) begin err++; $display("FAIL reset_out: got %b want %b", obs, e); end
      vec++;
      if (stall_cnt !== '0 || flush_cnt !== '0) begin
         err++; $display("FAIL reset_cnt: stall %0d flush %0d want 0 0", stall_cnt, flush_cnt);
      end
      drive('0);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_load_use();
      stim_t s[5]; exp_t x[5]; exp_t e;
      s[0] = st(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      x[0] = mk(7'b1100010, 2'b00, 2'b00, 1'b0);
      s[1] = '0;
      x[1] = mk(7'b0, 2'b00, 2'b00, 1'b0);
      s[2] = st(1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      x[2] = mk(7'b1100010, 2'b00, 2'b00, 1'b0);
      s[3] = st(1'b1, 5'd9, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      x[3] = mk(7'b0, 2'b00, 2'b00, 1'b0);
      s[4] = st(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      x[4] = mk(7'b0, 2'b00, 2'b00, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(s[i]); push(x[i]);
         @(negedge clk);
         e = sb.pop_front(); vec++;
         if (obs !== e) begin err++; $display("FAIL load_use[%0d]: got %b want %b", i, obs, e); end
         @(posedge clk); #1;
      end
      vec++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
         err++; $display("FAIL load_use_cnt: stall %0d flush %0d want %0d %0d",
                         stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
   endtask

   task automatic test_branch();
      stim_t s[4]; exp_t x[4]; exp_t e;
      s[0] = st(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      x[0] = mk(7'b0, 2'b00, 2'b00, 1'b0);
      s[1] = st(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      x[1] = mk(7'b0000110, 2'b00, 2'b00, 1'b0);
      s[2] = st(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      x[2] = mk(7'b0000110, 2'b00, 2'b00, 1'b0);
      s[3] = '0;
      x[3] = mk(7'b0, 2'b00, 2'b00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drive(s[i]); push(x[i]);
         @(negedge clk);
         e = sb.pop_front(); vec++;
         if (obs !== e) begin err++; $display("FAIL branch[%0d]: got %b want %b", i, obs, e); end
         @(posedge clk); #1;
      end
      vec++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
         err++; $display("FAIL branch_cnt: stall %0d flush %0d want %0d %0d",
                         stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
   endtask

   task automatic test_forward();
      stim_t s[7]; exp_t x[7]; exp_t e;
      s[0] = st(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd0, 5'd7, 5'd7, 1'b1, 1'b1);
      x[0] = mk(7'b0, 2'b10, 2'b00, 1'b0);
      s[1] = st(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd0, 5'd7, 5'd7, 1'b0, 1'b1);
      x[1] = mk(7'b0, 2'b01, 2'b00, 1'b0);
      s[2] = st(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 5'd7, 1'b1, 1'b1);
      x[2] = mk(7'b0, 2'b00, 2'b00, 1'b0);
      s[3] = st(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
      x[3] = mk(7'b0, 2'b00, 2'b00, 1'b0);
      s[4] = st(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd4, 5'd6, 5'd6, 5'd4, 1'b1, 1'b1);
      x[4] = mk(7'b0, 2'b01, 2'b10, 1'b0);
      s[5] = st(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd4, 5'd4, 5'd4, 5'd4, 1'b1, 1'b0);
      x[5] = mk(7'b0, 2'b10, 2'b10, 1'b0);
      s[6] = st(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd4, 5'd4, 5'd4, 5'd4, 1'b0, 1'b0);
      x[6] = mk(7'b0, 2'b00, 2'b00, 1'b0);
      for (int i = 0; i < 7; i++) begin
         drive(s[i]); push(x[i]);
         @(negedge clk);
         e = sb.pop_front(); vec++;
         if (obs !== e) begin err++; $display("FAIL forward[%0d]: got %b want %b", i, obs, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_wait();
      stim_t s[14]; exp_t x[14]; exp_t e;
      exp_t frz, idle, br, lu;
      frz  = mk(7'b1111001, 2'b00, 2'b00, 1'b0);
      idle = mk(7'b0, 2'b00, 2'b00, 1'b0);
      br   = mk(7'b0000110, 2'b00, 2'b00, 1'b0);
      lu   = mk(7'b1100010, 2'b00, 2'b00, 1'b0);
      s[0]  = st(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      x[0]  = frz;
      s[1]  = s[0]; x[1] = frz;
      s[2]  = st(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd7, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0);
      x[2]  = mk(7'b1111001, 2'b10, 2'b00, 1'b0);
      s[3]  = st(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      x[3]  = idle;
      s[4]  = '0; x[4] = idle;
      s[5]  = s[3]; x[5] = idle;
      s[6]  = '0; x[6] = idle;
      s[7]  = st(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      x[7]  = frz;
      s[8]  = s[7]; x[8] = frz;
      s[9]  = st(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      x[9]  = br;
      s[10] = st(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      x[10] = lu;
      s[11] = st(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      x[11] = frz;
      s[12] = st(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      x[12] = lu;
      s[13] = '0; x[13] = idle;
      for (int i = 0; i < 14; i++) begin
         drive(s[i]); push(x[i]);
         @(negedge clk);
         e = sb.pop_front(); vec++;
         if (obs !== e) begin err++; $display("FAIL mem_wait[%0d]: got %b want %b", i, obs, e); end
         @(posedge clk); #1;
      end
      vec++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
         err++; $display("FAIL mem_wait_cnt: stall %0d flush %0d want %0d %0d",
                         stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
   endtask

   task automatic test_timeout();
      stim_t wt, rdy; exp_t e;
      wt  = st(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      rdy = st(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      // one RUN request cycle, then TMO wait cycles before the flag shows
      for (int i = 0; i < TMO + 3; i++) begin
         drive(wt);
         push(mk(7'b1111001, 2'b00, 2'b00, (i > TMO) ? 1'b1 : 1'b0));
         @(negedge clk);
         e = sb.pop_front(); vec++;
         if (obs !== e) begin err++; $display("FAIL timeout[%0d]: got %b want %b", i, obs, e); end
         @(posedge clk); #1;
      end
      drive(rdy); push(mk(7'b0, 2'b00, 2'b00, 1'b1));
      @(negedge clk);
      e = sb.pop_front(); vec++;
      if (obs !== e) begin err++; $display("FAIL timeout_sticky: got %b want %b", obs, e); end
      @(posedge clk); #1;
      drive(wt); push(mk(7'b1111001, 2'b00, 2'b00, 1'b1));
      @(negedge clk);
      e = sb.pop_front(); vec++;
      if (obs !== e) begin err++; $display("FAIL timeout_rewait: got %b want %b", obs, e); end
      @(posedge clk); #2;
      rst = 1'b1;
      exp_stall = '0; exp_flush = '0;
      push(mk(7'b0, 2'b00, 2'b00, 1'b0));
      #1;
      e = sb.pop_front(); vec++;
      if (obs !== e) begin err++; $display("FAIL async_rst_out: got %b want %b", obs, e); end
      vec++;
      if (stall_cnt !== '0 || flush_cnt !== '0) begin
         err++; $display("FAIL async_rst_cnt: stall %0d flush %0d want 0 0", stall_cnt, flush_cnt);
      end
      drive('0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      drive('0); push(mk(7'b0, 2'b00, 2'b00, 1'b0));
      @(negedge clk);
      e = sb.pop_front(); vec++;
      if (obs !== e) begin err++; $display("FAIL post_rst_run: got %b want %b", obs, e); end
      @(posedge clk); #1;
   endtask

   task automatic test_cnt_wrap();
      exp_t e;
      drive(st(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0));
      for (int i = 0; i < (1 << CNT_W); i++) begin
         push(mk(7'b1100010, 2'b00, 2'b00, 1'b0));
         @(negedge clk);
         e = sb.pop_front(); vec++;
         if (obs !== e) begin err++; $display("FAIL wrap_out[%0d]: got %b want %b", i, obs, e); end
         @(posedge clk); #1;
         if (i == (1 << CNT_W) - 2) begin
            vec++;
            if (stall_cnt !== exp_stall || flush_cnt !== exp_flush || exp_stall !== '1) begin
               err++; $display("FAIL wrap_max: stall %0d flush %0d want %0d %0d",
                               stall_cnt, flush_cnt, exp_stall, exp_flush);
            end
         end
      end
      vec++;
      if (stall_cnt !== '0 || flush_cnt !== '0) begin
         err++; $display("FAIL wrap_zero: stall %0d flush %0d want 0 0", stall_cnt, flush_cnt);
      end
      drive('0);
   endtask

   initial begin
      drive('0);
      test_reset();
      test_load_use();
      test_branch();
      test_forward();
      test_mem_wait();
      test_timeout();
      test_cnt_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
